// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac
//   Fractional phase-accumulator baud generator. Every uart_clk edge the
//   phase increment is added to an ACC_WIDTH-bit accumulator. Each carry out
//   of the accumulator is one oversample tick. A modulo-OVERSAMPLE counter of
//   those ticks marks the bit tick and the mid-bit tick.
//
//   Build option: UART_BAUD_GEN_FRAC_SAFE_LOAD_EN
//     defined   - cfg_load only stages the new increment. The staged value
//                 takes effect on the bit-tick edge or on uart_resync, so the
//                 rate only ever changes at a bit boundary.
//     undefined - cfg_load writes the increment directly.
//
// Ports
//   uart_clk      in   clock, rising edge
//   uart_rst      in   synchronous active-high reset
//   uart_hold     in   freeze phase and counter, suppress ticks
//   uart_resync   in   restart bit phase (RX start-bit edge)
//   cfg_inc       in   new phase increment (ACC_WIDTH bits)
//   cfg_load      in   1-cycle strobe: take cfg_inc
//   uart_os_ena   out  oversample tick, 1-cycle pulse
//   uart_ena      out  bit tick, 1-cycle pulse
//   uart_ena_mid  out  mid-bit tick, 1-cycle pulse
module uart_baud_gen_frac #(
  parameter int unsigned BAUD_CLOCK_SPEED = 100000000,
  parameter int unsigned BAUD_RATE        = 115200,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned ACC_WIDTH        = 32
) (
  input  logic                 uart_clk,
  input  logic                 uart_rst,
  input  logic                 uart_hold,
  input  logic                 uart_resync,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic                 cfg_load,
  output logic                 uart_os_ena,
  output logic                 uart_ena,
  output logic                 uart_ena_mid
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  localparam longint unsigned DEF_INC_L =
    (((64'(BAUD_RATE) * 64'(OVERSAMPLE)) << ACC_WIDTH) + 64'(BAUD_CLOCK_SPEED / 2))
    / 64'(BAUD_CLOCK_SPEED);

  localparam logic [ACC_WIDTH-1:0] DEF_INC  = ACC_WIDTH'(DEF_INC_L);
  localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);

  if (DEF_INC_L == 64'd0 || DEF_INC_L >= (64'd1 << ACC_WIDTH)) begin : g_bad_def_inc
    $error("uart_baud_gen_frac: default increment out of range for ACC_WIDTH");
  end
  if (OVERSAMPLE < 2 || OVERSAMPLE > 256 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_baud_gen_frac: OVERSAMPLE must be even, 2..256");
  end
  if (ACC_WIDTH < 8 || ACC_WIDTH > 32) begin : g_bad_acc
    $error("uart_baud_gen_frac: ACC_WIDTH must be 8..32");
  end

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic                 os_ena_q, os_ena_d;
  logic                 ena_q, ena_d;
  logic                 ena_mid_q, ena_mid_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic                 os_last;
  logic                 os_mid;

`ifdef UART_BAUD_GEN_FRAC_SAFE_LOAD_EN
  logic [ACC_WIDTH-1:0] pend_inc_q, pend_inc_d;
  logic                 pend_vld_q, pend_vld_d;
`endif

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, inc_q};
    carry   = sum[ACC_WIDTH];
    os_last = (os_cnt_q == OS_LAST);
    os_mid  = (os_cnt_q == OS_MID);

    acc_d     = acc_q;
    inc_d     = inc_q;
    os_cnt_d  = os_cnt_q;
    os_ena_d  = 1'b0;
    ena_d     = 1'b0;
    ena_mid_d = 1'b0;
`ifdef UART_BAUD_GEN_FRAC_SAFE_LOAD_EN
    pend_inc_d = pend_inc_q;
    pend_vld_d = pend_vld_q;
`endif

    if (uart_resync) begin
      // Restart the bit from phase zero; a load on this edge is dropped.
      acc_d    = '0;
      os_cnt_d = '0;
`ifdef UART_BAUD_GEN_FRAC_SAFE_LOAD_EN
      if (pend_vld_q) begin
        inc_d      = pend_inc_q;
        pend_vld_d = 1'b0;
      end
`endif
    end else begin
      if (!uart_hold) begin
        acc_d     = sum[ACC_WIDTH-1:0];
        os_ena_d  = carry;
        ena_d     = carry && os_last;
        ena_mid_d = carry && os_mid;
        if (carry) begin
          os_cnt_d = os_last ? '0 : os_cnt_q + OS_W'(1);
        end
`ifdef UART_BAUD_GEN_FRAC_SAFE_LOAD_EN
        // Staged rate takes over exactly at the bit boundary.
        if (carry && os_last && pend_vld_q) begin
          inc_d      = pend_inc_q;
          pend_vld_d = 1'b0;
        end
`endif
      end
      // Loading is not masked by hold; this edge still used the old inc.
      if (cfg_load) begin
`ifdef UART_BAUD_GEN_FRAC_SAFE_LOAD_EN
        pend_inc_d = cfg_inc;
        pend_vld_d = 1'b1;
`else
        inc_d = cfg_inc;
`endif
      end
    end
  end

  always_ff @(posedge uart_clk) begin
    if (uart_rst) begin
      acc_q     <= '0;
      inc_q     <= DEF_INC;
      os_cnt_q  <= '0;
      os_ena_q  <= 1'b0;
      ena_q     <= 1'b0;
      ena_mid_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      inc_q     <= inc_d;
      os_cnt_q  <= os_cnt_d;
      os_ena_q  <= os_ena_d;
      ena_q     <= ena_d;
      ena_mid_q <= ena_mid_d;
    end
  end

`ifdef UART_BAUD_GEN_FRAC_SAFE_LOAD_EN
  always_ff @(posedge uart_clk) begin
    if (uart_rst) begin
      pend_vld_q <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
    end
  end

  // Staged value is only consumed when the flag is set, so it needs no reset.
  always_ff @(posedge uart_clk) begin
    pend_inc_q <= pend_inc_d;
  end
`endif

  assign uart_os_ena  = os_ena_q;
  assign uart_ena     = ena_q;
  assign uart_ena_mid = ena_mid_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac
//   Drives uart_baud_gen_frac (ACC_WIDTH=8, OVERSAMPLE=16) with directed and
//   randomized sequences. A reference model tracks the total accumulated
//   phase as an unbounded integer and counts oversample ticks since the last
//   resync; each cycle's expected tick triple is queued for a monitor that
//   compares it against the DUT one clock later.
module tb_uart_baud_gen_frac;

  localparam int unsigned CLK_HZ = 100000000;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned OS     = 16;
  localparam int unsigned AW     = 8;
  localparam longint      MODV   = 64'd1 << AW;
  localparam longint      DEFV   =
    (((64'(BAUD) * 64'(OS)) << AW) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic          resync = 1'b0;
  logic [AW-1:0] cfg_inc = '0;
  logic          cfg_load = 1'b0;
  logic          os_ena, ena, ena_mid;

  uart_baud_gen_frac #(
    .BAUD_CLOCK_SPEED(CLK_HZ),
    .BAUD_RATE       (BAUD),
    .OVERSAMPLE      (OS),
    .ACC_WIDTH       (AW)
  ) dut (
    .uart_clk    (clk),
    .uart_rst    (rst),
    .uart_hold   (hold),
    .uart_resync (resync),
    .cfg_inc     (cfg_inc),
    .cfg_load    (cfg_load),
    .uart_os_ena (os_ena),
    .uart_ena    (ena),
    .uart_ena_mid(ena_mid)
  );

  always #5 clk = ~clk;

  logic [2:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         model_ena_cnt = 0;
  int         dut_ena_cnt = 0;

  // Reference model state
  longint m_total = 0;
  longint m_inc   = DEFV;
  longint m_ticks = 0;
  bit     m_pv    = 1'b0;
  longint m_pend  = 0;

  task automatic step(input bit r, input bit rs, input bit h, input bit ld,
                      input logic [AW-1:0] ci);
    logic [2:0] e;
    longint     nt;
    bit         c;
    @(negedge clk);
    rst = r; resync = rs; hold = h; cfg_load = ld; cfg_inc = ci;
    cyc++;
    e = 3'b000;
    if (r) begin
      m_total = 0; m_inc = DEFV; m_ticks = 0; m_pv = 1'b0;
    end else if (rs) begin
      m_total = 0; m_ticks = 0;
`ifdef UART_BAUD_GEN_FRAC_SAFE_LOAD_EN
      if (m_pv) begin m_inc = m_pend; m_pv = 1'b0; end
`endif
    end else begin
      if (!h) begin
        nt = m_total + m_inc;
        c  = (nt / MODV) != (m_total / MODV);
        m_total = nt;
        if (c) begin
          m_ticks++;
          e[2] = 1'b1;
          e[1] = (m_ticks % OS) == 0;
          e[0] = (m_ticks % OS) == (OS / 2);
`ifdef UART_BAUD_GEN_FRAC_SAFE_LOAD_EN
          if (e[1] && m_pv) begin m_inc = m_pend; m_pv = 1'b0; end
`endif
        end
      end
      if (ld) begin
`ifdef UART_BAUD_GEN_FRAC_SAFE_LOAD_EN
        m_pend = longint'(ci); m_pv = 1'b1;
`else
        m_inc = longint'(ci);
`endif
      end
    end
    if (e[1]) model_ena_cnt++;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: compare one queued expectation per clock, just after the edge.
  initial begin
    logic [2:0] e;
    logic [2:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {os_ena, ena, ena_mid};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL ticks cyc=%0d got(os,ena,mid)=%b expected=%b", cyc, got, e);
        end
        if (got[1] === 1'b1) dut_ena_cnt++;
      end
    end
  end

  initial begin
    logic [AW-1:0] rv;
    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    // Free run at 0x40
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h40);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    run(200);
    // Fractional rate 0x30 from a clean phase
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h30);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    run(1000);
    // Random hold at 0x40
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h40);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 400; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);
    // Resync at os_cnt=9 (37 edges after a resync at 0x40), then sporadic
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    run(37);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    run(80);
    for (int i = 0; i < 300; i++) step(1'b0, ($urandom_range(0, 99) == 0), 1'b0, 1'b0, '0);
    // Mid-bit rate change to 0x80
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    run(40);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h80);
    run(200);
    // Reset mid-bit, then all controls together
    run(30);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    run(50);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h90);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
    run(150);
    // Disable via inc == 0
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    run(100);
    // Fully random mix
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 9) == 0) ? 8'h00 : AW'($urandom_range(8, 255));
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 149) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 99) == 0),
           rv);
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    checks++;
    if (dut_ena_cnt != model_ena_cnt) begin
      errors++;
      $display("FAIL ena_count got=%0d required=%0d", dut_ena_cnt, model_ena_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
